pattern_scan_engine: RTL and testbench
======================================

Name: pattern_scan_engine

Overview:
Hardware accelerator for program 3 (5-bit pattern count). On a start pulse it reads the pattern byte and the 32-byte message from data memory through a synchronous read port. It computes three 8-bit counts: matches without byte crossing, bytes containing at least one match, and matches with byte crossing. It writes the three counts back to data memory and raises done. It sits beside the data memory inside top_level and is the consumer of the memory image the program-3 bench preloads.

Parameters:
STR_BYTES, 32, number of message bytes, stored at addresses 0..STR_BYTES-1; byte 0 is the most significant byte of the bit string.
PAT_ADDR, 32, address of the pattern byte; the pattern is bits [4:0] and bits [7:5] are ignored.
RES_BASE, 33, results go to RES_BASE (ctb), RES_BASE+1 (cto) and RES_BASE+2 (cts).
AW, 8, memory address width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  single-cycle request; sampled only in IDLE or DONE
mem_addr  out  AW  memory address, for reads and writes
mem_rd_en  out  1  read strobe; mem_rdata is valid exactly one cycle later
mem_rdata  in  8  read data
mem_wr_en  out  1  write strobe; memory commits mem_wdata to mem_addr at the clock edge
mem_wdata  out  8  write data
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  high in DONE; stays high until the next accepted start or reset

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - busy, done, mem_rd_en and mem_wr_en go to 0; mem_addr and mem_wdata go to 0.
  - All counters, the pattern register and the previous-byte register clear.
- FSM states: IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
- IDLE/DONE with start=1 at an edge: go to LOAD_PAT, clear the counters, done goes to 0, busy goes to 1.
- Start while busy is ignored.
- LOAD_PAT (1 cycle): mem_addr=PAT_ADDR, mem_rd_en=1. Then go to SCAN with k=0.
- SCAN, k = 0..STR_BYTES (33 cycles):
  - While k<STR_BYTES: issue a read of address k.
  - At k=0: latch pat = mem_rdata[4:0].
  - At k>=1: process byte b = mem_rdata, which is message byte k-1.
  - In-byte windows: b[4:0], b[5:1], b[6:2], b[7:3]. Let m = number equal to pat (0..4).
  - ctb += m. cto += (m!=0). cts += m.
  - Crossing, only for k>=2: form w = {prev[3:0], b}. Count matches among w[8:4], w[9:5], w[10:6], w[11:7] and add them to cts.
  - After processing, prev <= b.
  - After k=STR_BYTES, go to WR_CTB.
- WR_CTB, WR_CTO, WR_CTS (1 cycle each): mem_wr_en=1, mem_addr=RES_BASE+0/1/2, mem_wdata=ctb/cto/cts. Then go to DONE.
- Latency: done rises at the 37th rising edge after the edge that accepts start (1 + 33 + 3 cycles of work).
- mem_wr_en is high for exactly 3 cycles per run and never during reads. mem_rd_en is high for exactly 33 cycles.
- Widths: counters are 8-bit with no saturation needed. Maxima are ctb 128, cto 32, cts 252 (4 per byte plus 4 per boundary × 31).
- Reset mid-operation: abort immediately; no further reads or writes; results already written stay in memory.
- start and reset are synchronous to clk. reset deassertion is synchronised internally with a 2-flop release.

Test Plan:
- All 32 bytes 0x00, core[32]=0x00, start pulse -> core[33]=128, core[34]=32, core[35]=252; done rises 37 edges after start.
- All bytes 0x55, pattern 0x15 -> ctb=64, cto=32, cts=126.
- Byte0=0x01, byte1=0xE0, rest 0x00, pattern 0x0F -> ctb=0, cto=0, cts=1 (crossing window only).
- core[32]=0xE0 with all-zero message -> same results as the first scenario (pattern upper bits ignored).
- Reset asserted at SCAN k=10 -> busy, done, mem_wr_en drop to 0 at once, core[33..35] unchanged. A new start then yields the correct counts.
- Second start pulse during SCAN -> ignored: exactly 3 writes and a single done rise. Start while in DONE -> done drops and a full rerun produces identical results.

Source files
------------

// File: rtl/pattern_scan_engine.sv
// Program-3 accelerator: counts 5-bit pattern hits in a 32-byte message read from
// data memory, then writes ctb/cto/cts back to memory and raises done.

module pse_win_match (
  input  logic [4:0] i_win,
  input  logic [4:0] i_pat,
  output logic       o_hit
);
  assign o_hit = (i_win == i_pat);
endmodule

module pattern_scan_engine #(
  parameter int STR_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_BASE  = 33,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done
);
  localparam int KW     = $clog2(STR_BYTES + 1);
  localparam int NUM_WIN = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_PAT, S_SCAN, S_WR_CTB, S_WR_CTO, S_WR_CTS, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [KW-1:0] r_k;
  logic [4:0]    r_pat;
  logic [7:0]    r_prev;
  logic [7:0]    r_ctb, r_cto, r_cts;

  logic [11:0]                   w_bits;
  logic [NUM_WIN-1:0][4:0]       w_win;
  logic [NUM_WIN-1:0]            w_hit;
  logic [2:0]                    w_m;
  logic [2:0]                    w_x;
  logic                          w_accept;

  // Assertion reaches the core immediately; release is delayed two edges.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  // Windows 0..3 sit inside the current byte, 4..7 straddle the previous byte.
  assign w_bits = {r_prev[3:0], mem_rdata};
  genvar g;
  generate
    for (g = 0; g < NUM_WIN; g++) begin : g_win
      assign w_win[g] = w_bits[g+4:g];
      pse_win_match u_match (.i_win(w_win[g]), .i_pat(r_pat), .o_hit(w_hit[g]));
    end
  endgenerate

  always_comb begin
    w_m = 3'd0;
    w_x = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_m = w_m + {2'b00, w_hit[i]};
      w_x = w_x + {2'b00, w_hit[i+4]};
    end
  end

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_LOAD_PAT;
      S_LOAD_PAT:     w_state_nxt = S_SCAN;
      S_SCAN:         if (r_k == KW'(STR_BYTES)) w_state_nxt = S_WR_CTB;
      S_WR_CTB:       w_state_nxt = S_WR_CTO;
      S_WR_CTO:       w_state_nxt = S_WR_CTS;
      S_WR_CTS:       w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 8'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_DONE: begin busy = 1'b0; done = 1'b1; end
      S_LOAD_PAT: begin mem_addr = AW'(PAT_ADDR); mem_rd_en = 1'b1; end
      S_SCAN: if (r_k < KW'(STR_BYTES)) begin
        mem_addr  = AW'(r_k);
        mem_rd_en = 1'b1;
      end
      S_WR_CTB: begin mem_addr = AW'(RES_BASE);     mem_wr_en = 1'b1; mem_wdata = r_ctb; end
      S_WR_CTO: begin mem_addr = AW'(RES_BASE + 1); mem_wr_en = 1'b1; mem_wdata = r_cto; end
      S_WR_CTS: begin mem_addr = AW'(RES_BASE + 2); mem_wr_en = 1'b1; mem_wdata = r_cts; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_k    <= '0;
      r_pat  <= 5'd0;
      r_prev <= 8'd0;
      r_ctb  <= 8'd0;
      r_cto  <= 8'd0;
      r_cts  <= 8'd0;
    end else if (w_accept) begin
      r_k    <= '0;
      r_prev <= 8'd0;
      r_ctb  <= 8'd0;
      r_cto  <= 8'd0;
      r_cts  <= 8'd0;
    end else if (r_state == S_LOAD_PAT) begin
      r_k <= '0;
    end else if (r_state == S_SCAN) begin
      r_k <= r_k + 1'b1;
      if (r_k == '0) begin
        r_pat <= mem_rdata[4:0];
      end else begin
        r_ctb  <= r_ctb + {5'd0, w_m};
        r_cto  <= r_cto + {7'd0, (w_m != 3'd0)};
        r_cts  <= r_cts + {5'd0, w_m} + ((r_k >= KW'(2)) ? {5'd0, w_x} : 8'd0);
        r_prev <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed bench for pattern_scan_engine with a write scoreboard and a behavioural memory.
`timescale 1ns/1ps
module tb_pattern_scan_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;

  logic [7:0] core [0:255];
  logic       ld_en;
  logic [7:0] ld_a, ld_d;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t sb_q [$];

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int done_rises = 0;

  always #5 clk = ~clk;

  pattern_scan_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (ld_en) core[ld_a] <= ld_d;
    else if (mem_wr_en) core[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= core[mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every DUT write is popped against the scoreboard.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (done && !done_q) done_rises++;
    done_q <= done;
    if (mem_wr_en) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr %0d data %0d", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || mem_rd_en !== 1'b0) begin
          bad++;
          $display("FAIL write: got addr %0d data %0d rd %0b expected addr %0d data %0d rd 0",
                   mem_addr, mem_wdata, mem_rd_en, e.addr, e.data);
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] pat, input logic [7:0] fillb);
    for (int i = 0; i < 32; i++) load(8'(i), fillb);
    load(8'd32, pat);
  endtask

  task automatic push_exp(input int ctb, input int cto, input int cts);
    wr_t e;
    e.addr = 8'd33; e.data = 8'(ctb); sb_q.push_back(e);
    e.addr = 8'd34; e.data = 8'(cto); sb_q.push_back(e);
    e.addr = 8'd35; e.data = 8'(cts); sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input string name, input int ctb, input int cto, input int cts,
                     input bit dup_start);
    int n;
    push_exp(ctb, cto, cts);
    rd_cnt = 0;
    done_rises = 0;
    pulse_start();
    check({name, "_busy_after_accept"}, int'(busy), 1);
    check({name, "_done_after_accept"}, int'(done), 0);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      if (dup_start && i == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin n = i; break; end
    end
    if (n == 0) begin
      bad++; total++;
      $display("FAIL %s_timeout: done not seen within 60 edges, expected 37", name);
    end else begin
      check({name, "_latency"}, n, 37);
    end
    repeat (2) @(negedge clk);
    check({name, "_pending_writes"}, sb_q.size(), 0);
    check({name, "_rd_cycles"}, rd_cnt, 33);
    check({name, "_done_rises"}, done_rises, 1);
    check({name, "_done_held"}, int'(done), 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ld_en = 1'b0; ld_a = 8'd0; ld_d = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_wr_en", int'(mem_wr_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk); #1;

    fill(8'h00, 8'h00);
    run("zeros", 128, 32, 252, 1'b0);

    fill(8'h15, 8'h55);
    run("alt55", 64, 32, 126, 1'b0);

    fill(8'h0F, 8'h00);
    load(8'd0, 8'h01);
    load(8'd1, 8'hE0);
    run("cross_only", 0, 0, 1, 1'b0);

    fill(8'hE0, 8'h00);
    run("pat_hi_ignored", 128, 32, 252, 1'b0);

    // Abort at SCAN k=10; memory results from the previous run must survive.
    fill(8'h15, 8'h55);
    pulse_start();
    repeat (11) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wr_en", int'(mem_wr_en), 0);
    check("abort_rd_en", int'(mem_rd_en), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("abort_core33", int'(core[33]), 128);
    check("abort_core34", int'(core[34]), 32);
    check("abort_core35", int'(core[35]), 252);
    run("after_abort", 64, 32, 126, 1'b0);

    run("dup_start", 64, 32, 126, 1'b1);
    run("rerun_from_done", 64, 32, 126, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
